// File: rtl/muldiv_unit_if.sv
// Request/result bundle between EX and the HI/LO path.
// master drives start/op/a/b/flush; slave returns busy and HI/LO pulses.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_data;
  logic [31:0] lo_data;

  modport master (
    output start, op, a, b, flush,
    input  busy, hi_write, lo_write,
    input  hi_data, lo_data
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, hi_write, lo_write,
    output hi_data, lo_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit feeding HI/LO.
// Ports: clk, reset (sync, high), io (slave): start/op/a/b/flush in; busy + HI/LO pulses out.
module muldiv_unit #(
  parameter int MUL_LATENCY = 4
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave io
);
  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX, S_WB
  } state_e;

  localparam logic [7:0] MUL_LAST = 8'(MUL_LATENCY - 2);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        busy_q, busy_d;
  logic        hw_q, hw_d;
  logic        lw_q, lw_d;
  logic [31:0] hd_q, hd_d;
  logic [31:0] ld_q, ld_d;

  logic               accept;
  logic signed [63:0] m_a, m_b, prod;
  logic [32:0]        trial, diff;
  logic [31:0]        q_fix, r_fix;

  function automatic logic [31:0] mag(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  assign accept = io.start && !busy_q &&
                  !io.flush && (io.op < 3'd6);

  // Low 64 bits of the extended product are exact
  // for both signed and unsigned 32x32.
  assign m_a  = {{32{sgn_q & opa_q[31]}}, opa_q};
  assign m_b  = {{32{sgn_q & opb_q[31]}}, opb_q};
  assign prod = m_a * m_b;

  // One restoring step: shift next dividend bit in.
  assign trial = {rem_q, quo_q[31]};
  assign diff  = trial - {1'b0, dvs_q};

  assign q_fix = (sgn_q && (opa_q[31] ^ opb_q[31])) ?
                 (~quo_q + 32'd1) : quo_q;
  assign r_fix = (sgn_q && opa_q[31]) ?
                 (~rem_q + 32'd1) : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    busy_d  = busy_q;
    hw_d    = 1'b0;
    lw_d    = 1'b0;
    hd_d    = 32'd0;
    ld_d    = 32'd0;
    unique case (state_q)
      S_IDLE, S_WB: begin
        state_d = S_IDLE;
        if (accept) begin
          opa_d = io.a;
          opb_d = io.b;
          sgn_d = !io.op[0];
          cnt_d = 8'd0;
          unique case (1'b1)
            io.op[2]: begin
              state_d = S_WB;
              if (io.op[0]) begin
                lw_d = 1'b1;
                ld_d = io.a;
              end else begin
                hw_d = 1'b1;
                hd_d = io.a;
              end
            end
            io.op[1]: begin
              state_d = S_DIV;
              busy_d  = 1'b1;
              rem_d   = 32'd0;
              quo_d   = mag(io.a, !io.op[0]);
              dvs_d   = mag(io.b, !io.op[0]);
            end
            default: begin
              state_d = S_MUL;
              busy_d  = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == MUL_LAST) begin
          state_d = S_WB;
          busy_d  = 1'b0;
          hw_d    = 1'b1;
          lw_d    = 1'b1;
          hd_d    = prod[63:32];
          ld_d    = prod[31:0];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DIV: begin
        if (diff[32]) begin
          rem_d = trial[31:0];
        end else begin
          rem_d = diff[31:0];
        end
        quo_d = {quo_q[30:0], ~diff[32]};
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_WB;
        busy_d  = 1'b0;
        hw_d    = 1'b1;
        lw_d    = 1'b1;
        if (opb_q == 32'd0) begin
          hd_d = opa_q;
          ld_d = 32'hFFFF_FFFF;
        end else begin
          hd_d = r_fix;
          ld_d = q_fix;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // Abort kills any in-flight op and any pulse
    // it would have produced next cycle.
    if (io.flush) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      hw_d    = 1'b0;
      lw_d    = 1'b0;
      hd_d    = 32'd0;
      ld_d    = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      sgn_q   <= 1'b0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      busy_q  <= 1'b0;
      hw_q    <= 1'b0;
      lw_q    <= 1'b0;
      hd_q    <= 32'd0;
      ld_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      busy_q  <= busy_d;
      hw_q    <= hw_d;
      lw_q    <= lw_d;
      hd_q    <= hd_d;
      ld_q    <= ld_d;
    end
  end

  assign io.busy     = busy_q;
  assign io.hi_write = hw_q;
  assign io.lo_write = lw_q;
  assign io.hi_data  = hd_q;
  assign io.lo_data  = ld_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against a cycle-count model.
// Directed literal cases pin latencies and arithmetic corner values.
module tb_muldiv_unit;
  localparam int L = 4;

  logic clk;
  logic reset;
  muldiv_unit_if io ();

  muldiv_unit #(.MUL_LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       nm,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] ref_res(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint sa, sb;
    longint unsigned ua, ub;
    int qi, ri;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return 64'(ua * ub);
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'd0, 32'h8000_0000};
        qi = $signed(a) / $signed(b);
        ri = $signed(a) % $signed(b);
        return {32'(ri), 32'(qi)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Model: countdown of edges until the result pulse.
  bit          mvalid = 0;
  bit          m_busy, m_hw, m_lw;
  logic [31:0] m_hd, m_ld;
  int          m_cnt;
  logic [63:0] m_res;

  always @(posedge clk) begin
    bit was_busy;
    was_busy = m_busy;
    if (reset) begin
      mvalid = 1;
      m_busy = 0; m_cnt = 0;
      m_hw = 0; m_lw = 0;
      m_hd = 0; m_ld = 0;
    end else if (mvalid) begin
      m_hw = 0; m_lw = 0;
      m_hd = 0; m_ld = 0;
      if (io.flush) begin
        m_cnt = 0;
        m_busy = 0;
      end else begin
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy = 0;
            m_hw = 1; m_lw = 1;
            m_hd = m_res[63:32];
            m_ld = m_res[31:0];
          end
        end
        if (io.start && !was_busy && io.op < 6) begin
          if (io.op == 4) begin
            m_hw = 1; m_hd = io.a;
          end else if (io.op == 5) begin
            m_lw = 1; m_ld = io.a;
          end else begin
            m_res  = ref_res(io.op, io.a, io.b);
            m_cnt  = (io.op < 2) ? L - 1 : 33;
            m_busy = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("busy", 64'(io.busy), 64'(m_busy));
      chk("hi_write", 64'(io.hi_write), 64'(m_hw));
      chk("lo_write", 64'(io.lo_write), 64'(m_lw));
      if (m_hw) chk("hi_data", 64'(io.hi_data), 64'(m_hd));
      if (m_lw) chk("lo_data", 64'(io.lo_data), 64'(m_ld));
    end
  end

  task automatic run_op(
    input string       nm,
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          lat,
    input bit          ehw,
    input bit          elw,
    input logic [31:0] ehi,
    input logic [31:0] elo
  );
    int k;
    bit got;
    logic hw, lw;
    logic [31:0] hd, ld;
    @(posedge clk); #1;
    io.start = 1; io.op = op; io.a = a; io.b = b;
    @(posedge clk); #1;
    io.start = 0;
    io.a = $urandom; io.b = $urandom;
    k = 0; got = 0;
    hw = 0; lw = 0; hd = 0; ld = 0;
    while (!got && k < 60) begin
      @(negedge clk);
      k++;
      if (io.hi_write || io.lo_write) begin
        got = 1;
        hw = io.hi_write; lw = io.lo_write;
        hd = io.hi_data; ld = io.lo_data;
      end
    end
    chk({nm, "_latency"}, 64'(k), 64'(lat));
    chk({nm, "_hw"}, 64'(hw), 64'(ehw));
    chk({nm, "_lw"}, 64'(lw), 64'(elw));
    if (ehw) chk({nm, "_hi"}, 64'(hd), 64'(ehi));
    if (elw) chk({nm, "_lo"}, 64'(ld), 64'(elo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int pulses;
    reset = 1;
    io.start = 0; io.op = 0;
    io.a = 0; io.b = 0; io.flush = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_busy", 64'(io.busy), 64'd0);
    chk("rst_hw", 64'(io.hi_write), 64'd0);
    chk("rst_lw", 64'(io.lo_write), 64'd0);
    chk("rst_hd", 64'(io.hi_data), 64'd0);
    chk("rst_ld", 64'(io.lo_data), 64'd0);

    run_op("mthi", 3'd4, 32'h1234_5678, 32'd9,
           1, 1, 0, 32'h1234_5678, 32'd0);
    run_op("mtlo", 3'd5, 32'hCAFE_0001, 32'd9,
           1, 0, 1, 32'd0, 32'hCAFE_0001);
    run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd7,
           L, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu", 3'd1, 32'hFFFF_FFFD, 32'd7,
           L, 1, 1, 32'h0000_0006, 32'hFFFF_FFEB);
    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2,
           34, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd3, 32'd7, 32'd2,
           34, 1, 1, 32'd1, 32'd3);
    run_op("divu0", 3'd3, 32'd5, 32'd0,
           34, 1, 1, 32'd5, 32'hFFFF_FFFF);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
           34, 1, 1, 32'd0, 32'h8000_0000);

    // Flush in cycle N+10 of a DIV.
    @(posedge clk); #1;
    io.start = 1; io.op = 3'd2; io.a = 100; io.b = 3;
    @(posedge clk); #1;
    io.start = 0;
    repeat (9) @(posedge clk);
    #1 io.flush = 1;
    @(posedge clk); #1;
    io.flush = 0;
    chk("flush_busy", 64'(io.busy), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (io.hi_write || io.lo_write) pulses++;
    end
    chk("flush_nopulse", 64'(pulses), 64'd0);

    // Reset in cycle N+2 of a MULT.
    @(posedge clk); #1;
    io.start = 1; io.op = 3'd0; io.a = 3; io.b = 5;
    @(posedge clk); #1;
    io.start = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rstm_busy", 64'(io.busy), 64'd0);
    chk("rstm_w", 64'({io.hi_write, io.lo_write}), 64'd0);
    chk("rstm_data", {io.hi_data, io.lo_data}, 64'd0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (io.hi_write || io.lo_write) pulses++;
    end
    chk("rstm_nopulse", 64'(pulses), 64'd0);

    // Start held high with changing operands.
    @(posedge clk); #1;
    io.start = 1; io.op = 3'd3;
    repeat (80) begin
      io.a = pick(); io.b = pick();
      @(posedge clk); #1;
    end
    io.start = 0;

    // Random traffic, including flushes and illegal ops.
    repeat (3000) begin
      @(posedge clk); #1;
      io.start = ($urandom % 3) == 0;
      io.op    = 3'($urandom % 8);
      io.a     = pick();
      io.b     = pick();
      io.flush = ($urandom % 40) == 0;
    end
    @(posedge clk); #1;
    io.start = 0; io.flush = 0;
    repeat (40) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
